// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, port indexing and small header helpers
// used by the group router and its input FIFOs.
package noc_pkg;

  localparam int DATA_W     = 16;
  localparam int HEADER_W   = 6;
  localparam int NUM_PORTS  = 5;
  localparam int NUM_LEAVES = 4;
  localparam int UPLINK_IDX = 4;

  localparam int GROUP_HI = 15;
  localparam int GROUP_LO = 12;
  localparam int LEAF_HI  = 11;
  localparam int LEAF_LO  = 10;

  typedef logic [DATA_W-1:0] flit_t;
  typedef logic [2:0]        port_idx_t;

  function automatic logic [GROUP_HI-GROUP_LO:0] flit_group(flit_t f);
    return f[GROUP_HI:GROUP_LO];
  endfunction

  function automatic logic [LEAF_HI-LEAF_LO:0] flit_leaf(flit_t f);
    return f[LEAF_HI:LEAF_LO];
  endfunction

  function automatic logic header_is_null(flit_t f);
    return f[DATA_W-1:DATA_W-HEADER_W] == '0;
  endfunction

  // Round-robin successor over the five router ports.
  function automatic port_idx_t next_port(port_idx_t p);
    return (p == port_idx_t'(NUM_PORTS - 1)) ? port_idx_t'(0) : p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous show-ahead flit FIFO. The head flit is visible on data_o whenever
// valid_o is high; ready_o comes straight from the registered occupancy.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, do_pop;

  assign ready_o = count_q < CNT_W'(DEPTH);
  assign valid_o = count_q != '0;
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = valid_i && ready_o;
  assign do_pop  = pop_i && valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/group_router.sv
// Group-level NoC router: four leaf ports plus one uplink, each input buffered
// by a show-ahead FIFO and each output served by its own round-robin arbiter.
module group_router
  import noc_pkg::*;
#(
  parameter logic [3:0] GROUP_ID   = 4'd4,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] leaf_in_data,
  input  logic [3:0]  leaf_in_valid,
  output logic [3:0]  leaf_in_ready,
  output logic [63:0] leaf_out_data,
  output logic [3:0]  leaf_out_valid,
  output logic [15:0] up_tx_data,
  output logic        up_tx_valid,
  input  logic        up_tx_ready,
  input  logic [15:0] up_rx_data,
  input  logic        up_rx_valid,
  output logic        up_rx_ready,
  output logic [7:0]  drop_count
);

  flit_t                  in_data   [NUM_PORTS];
  flit_t                  head_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]   in_valid, in_ready, head_vld, pop, drop, out_open;
  port_idx_t              tgt       [NUM_PORTS];
  logic [NUM_PORTS-1:0]   req       [NUM_PORTS];
  logic [NUM_PORTS-1:0]   gnt_vld;
  port_idx_t              gnt_idx   [NUM_PORTS];
  port_idx_t              rr_ptr_q  [NUM_PORTS];
  port_idx_t              rr_ptr_d  [NUM_PORTS];

  logic [63:0] leaf_data_q, leaf_data_d;
  logic [3:0]  leaf_valid_q, leaf_valid_d;
  flit_t       up_data_q, up_data_d;
  logic        up_valid_q, up_valid_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [2:0]  n_drop;
  logic [8:0]  drop_sum;

  always_comb begin
    for (int i = 0; i < NUM_LEAVES; i++) begin
      in_data[i]  = leaf_in_data[i*DATA_W +: DATA_W];
      in_valid[i] = leaf_in_valid[i];
    end
    in_data[UPLINK_IDX]  = up_rx_data;
    in_valid[UPLINK_IDX] = up_rx_valid;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
    flit_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .valid_i (in_valid[g]),
      .data_i  (in_data[g]),
      .ready_o (in_ready[g]),
      .pop_i   (pop[g]),
      .valid_o (head_vld[g]),
      .data_o  (head_data[g])
    );
  end

  // Header decode at each FIFO head. Null headers and foreign-group flits
  // arriving from the parent are discarded without using any output.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      tgt[i]  = port_idx_t'(UPLINK_IDX);
      drop[i] = 1'b0;
      if (head_vld[i]) begin
        if (header_is_null(head_data[i])) begin
          drop[i] = 1'b1;
        end else if (flit_group(head_data[i]) == GROUP_ID) begin
          tgt[i] = {1'b0, flit_leaf(head_data[i])};
        end else if (i == UPLINK_IDX) begin
          drop[i] = 1'b1;
        end
      end
    end
  end

  // Leaf outputs never stall; the uplink register only takes a new flit when
  // it is empty or being consumed this cycle.
  assign out_open = {!up_valid_q || up_tx_ready, 4'b1111};

  always_comb begin
    pop = drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      port_idx_t idx;
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = head_vld[i] && !drop[i] && (tgt[i] == port_idx_t'(o)) && out_open[o];
      end
      idx = rr_ptr_q[o];
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!gnt_vld[o] && req[o][idx]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = idx;
        end
        idx = next_port(idx);
      end
      rr_ptr_d[o] = gnt_vld[o] ? next_port(gnt_idx[o]) : rr_ptr_q[o];
      if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    leaf_data_d  = leaf_data_q;
    leaf_valid_d = '0;
    for (int o = 0; o < NUM_LEAVES; o++) begin
      leaf_valid_d[o] = gnt_vld[o];
      if (gnt_vld[o]) leaf_data_d[o*DATA_W +: DATA_W] = head_data[gnt_idx[o]];
    end
    up_valid_d = up_valid_q;
    up_data_d  = up_data_q;
    if (out_open[UPLINK_IDX]) begin
      up_valid_d = gnt_vld[UPLINK_IDX];
      if (gnt_vld[UPLINK_IDX]) up_data_d = head_data[gnt_idx[UPLINK_IDX]];
    end
  end

  // Several inputs can discard in the same cycle, so add them all at once.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_PORTS; i++) n_drop = n_drop + {2'b00, drop[i]};
    drop_sum   = {1'b0, drop_cnt_q} + {6'b0, n_drop};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leaf_data_q  <= '0;
      leaf_valid_q <= '0;
      up_data_q    <= '0;
      up_valid_q   <= 1'b0;
      drop_cnt_q   <= '0;
      for (int o = 0; o < NUM_PORTS; o++) rr_ptr_q[o] <= '0;
    end else begin
      leaf_data_q  <= leaf_data_d;
      leaf_valid_q <= leaf_valid_d;
      up_data_q    <= up_data_d;
      up_valid_q   <= up_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      for (int o = 0; o < NUM_PORTS; o++) rr_ptr_q[o] <= rr_ptr_d[o];
    end
  end

  assign leaf_in_ready  = in_ready[NUM_LEAVES-1:0];
  assign up_rx_ready    = in_ready[UPLINK_IDX];
  assign leaf_out_data  = leaf_data_q;
  assign leaf_out_valid = leaf_valid_q;
  assign up_tx_data     = up_data_q;
  assign up_tx_valid    = up_valid_q;
  assign drop_count     = drop_cnt_q;

endmodule
